// File: rtl/serial_rx_pkg.sv
// Shared types and widths for the framed 4-bit serial receiver.
package serial_rx_pkg;

  localparam int unsigned RX_DATA_W = 4;
  localparam int unsigned RX_CNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/serial_rx_4_sipo.sv
// sipo_4: 4-bit serial-in/parallel-out shift register, shifts into the MSB.
module sipo_4
  import serial_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 din,
  output logic [RX_DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else if (shift) begin
      q <= {din, q[RX_DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/serial_rx_4.sv
// serial_rx_4: framed serial receiver (start, d0..d3 LSB first, [parity], stop).
// Define SERIAL_RX_PARITY_EN to add an even-parity bit after d3.
module serial_rx_4
  import serial_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 bit_en,
  input  logic                 ser_in,
  output logic [RX_DATA_W-1:0] a_par,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  rx_state_t             state;
  logic [RX_CNT_W-1:0]   cnt;
  logic [RX_DATA_W-1:0]  shreg;
  logic                  shift_en;
  logic                  parity_ok;

  assign shift_en = bit_en && (state == DATA);

  sipo_4 u_sipo (
    .clk   (clk),
    .clear (clear),
    .shift (shift_en),
    .din   (ser_in),
    .q     (shreg)
  );

`ifdef SERIAL_RX_PARITY_EN
  logic par_bit;
  assign parity_ok = ~(^{shreg, par_bit});
`else
  assign parity_ok = 1'b1;
`endif

  // Frame sequencer; every transition is gated by the bit strobe, pulses self-clear.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      a_par     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!ser_in) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            cnt <= cnt + RX_CNT_W'(1);
            if (cnt == RX_CNT_W'(RX_DATA_W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef SERIAL_RX_PARITY_EN
          PARITY: begin
            par_bit <= ser_in;
            state   <= STOP;
          end
`endif
          STOP: begin
            if (ser_in && parity_ok) begin
              a_par <= shreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_4.sv
// Scoreboard bench for serial_rx_4: directed frames push expected pulses, a monitor pops and checks.
module tb_serial_rx_4;

  logic       clk = 1'b0;
  logic       clear;
  logic       bit_en;
  logic       ser_in;
  logic [3:0] a_par;
  logic       valid;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic       is_err;
    logic [3:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] last_good = 4'b0000;
  logic       prev_pulse = 1'b0;

  serial_rx_4 dut (
    .clk       (clk),
    .clear     (clear),
    .bit_en    (bit_en),
    .ser_in    (ser_in),
    .a_par     (a_par),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Monitor: every output pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (valid || frame_err) begin
      check("pulse_width", 32'(prev_pulse), 32'(0));
      check("valid_err_excl", 32'(valid & frame_err), 32'(0));
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(frame_err), 32'(e.is_err));
        check("a_par", 32'(a_par), 32'(e.data));
      end
    end
    prev_pulse = valid || frame_err;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b, input int pace, input logic exp_busy, input string name);
    for (int i = 0; i < pace; i++) begin
      @(negedge clk);
      ser_in = b;
      bit_en = (i == pace - 1);
    end
    @(posedge clk);
    #1;
    check(name, 32'(busy), 32'(exp_busy));
  endtask

  task automatic idle(input int n, input logic chk_busy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ser_in = 1'b1;
      bit_en = 1'b1;
      @(posedge clk);
      #1;
      if (chk_busy) check("idle_busy", 32'(busy), 32'(0));
    end
  endtask

  task automatic send_frame(input logic [3:0] d, input logic stop, input logic par_flip, input int pace);
    logic exp_err;
    exp_t e;
    exp_err = !stop;
`ifdef SERIAL_RX_PARITY_EN
    exp_err = exp_err || par_flip;
`endif
    send_bit(1'b0, pace, 1'b1, "busy_start");
    for (int i = 0; i < 4; i++) send_bit(d[i], pace, 1'b1, "busy_data");
`ifdef SERIAL_RX_PARITY_EN
    send_bit((^d) ^ par_flip, pace, 1'b1, "busy_parity");
`endif
    e.is_err = exp_err;
    e.data   = exp_err ? last_good : d;
    sb.push_back(e);
    if (!exp_err) last_good = d;
    send_bit(stop, pace, 1'b0, "busy_stop");
    check("valid_on_stop_edge", 32'(valid), 32'(!exp_err));
    check("err_on_stop_edge", 32'(frame_err), 32'(exp_err));
  endtask

  initial begin
    clear  = 1'b1;
    bit_en = 1'b0;
    ser_in = 1'b1;
    #12;
    check("rst_a_par", 32'(a_par), 32'(0));
    check("rst_valid", 32'(valid), 32'(0));
    check("rst_err", 32'(frame_err), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    clear = 1'b0;
    idle(3, 1'b1);

    // Good frame 0,1,1,0,1,(parity),1 -> 4'b1011
    send_frame(4'b1011, 1'b1, 1'b0, 1);
    idle(2, 1'b1);

`ifdef SERIAL_RX_PARITY_EN
    // Wrong parity bit with good stop: error, a_par holds 4'b1011
    send_frame(4'b1011, 1'b1, 1'b1, 1);
    idle(2, 1'b1);
`endif

    // Bad stop bit on 4'b1000; the stop 0 must not start a frame
    send_frame(4'b1000, 1'b0, 1'b0, 1);
    idle(8, 1'b1);
    check("a_par_after_stop_err", 32'(a_par), 32'(4'b1011));

    // Paced back-to-back frames, bit_en every 4th clock
    send_frame(4'b1000, 1'b1, 1'b0, 4);
    send_frame(4'b0111, 1'b1, 1'b0, 4);
    idle(4, 1'b1);
    check("a_par_after_paced", 32'(a_par), 32'(4'b0111));

    // Abort mid-frame after the 2nd data bit
    send_bit(1'b0, 1, 1'b1, "busy_start");
    send_bit(1'b1, 1, 1'b1, "busy_data");
    send_bit(1'b1, 1, 1'b1, "busy_data");
    @(negedge clk);
    #2;
    clear = 1'b1;
    #1;
    check("clr_a_par", 32'(a_par), 32'(0));
    check("clr_valid", 32'(valid), 32'(0));
    check("clr_err", 32'(frame_err), 32'(0));
    check("clr_busy", 32'(busy), 32'(0));
    last_good = 4'b0000;
    @(negedge clk);
    clear  = 1'b0;
    ser_in = 1'b1;
    idle(6, 1'b1);
    check("clr_a_par_hold", 32'(a_par), 32'(0));

    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
